line_read_buffer: RTL
=====================

LINE_READ_BUFFER -- requirements
Module: line_read_buffer

Interface
REQ-001 SHALL have no parameters; all widths are fixed by lc3b_types.
REQ-002 SHALL use one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 mem_address  input  16 (lc3b_word)  CPU byte address; tag = [15:4], offset = [3:0].
REQ-006 mem_read  input  1  CPU read request; held high until mem_resp.
REQ-007 mem_byte_enable  input  2 (lc3b_mem_wmask)  byte lanes requested.
REQ-008 mem_rdata  output  16 (lc3b_word)  registered extracted data.
REQ-009 mem_resp  output  1  one-cycle read-complete pulse.
REQ-010 pmem_address  output  16  line-aligned fetch address; [3:0] = 0.
REQ-011 pmem_read  output  1  line fetch request; held until pmem_resp.
REQ-012 pmem_rdata  input  128 (lc3b_c_line)  fetched line; byte i = bits [8i+7:8i].
REQ-013 pmem_resp  input  1  fetch complete; pmem_rdata valid this cycle.
REQ-014 inval  input  1  line write/evict notice from the write path.
REQ-015 inval_address  input  16  address being invalidated; only [15:4] is compared.

Function
REQ-016 SHALL hold one buffered line: line register, 12-bit tag register and valid bit.
REQ-017 SHALL implement three states:
- IDLE: sample requests only in this state.
- FETCH: pmem_read = 1.
- RESPOND: mem_resp = 1.
REQ-018 In IDLE, mem_read with valid=1, tag match and no matching inval in the same cycle SHALL go to RESPOND (hit; mem_resp in the next cycle).
REQ-019 In IDLE, mem_read otherwise SHALL go to FETCH and capture pmem_address = {mem_address[15:4], 4'h0}.
REQ-020 FETCH SHALL persist until pmem_resp.
- On pmem_resp: load line and tag, set valid, go to RESPOND.
- mem_resp SHALL follow pmem_resp by one cycle.
REQ-021 RESPOND SHALL last exactly one cycle and then return to IDLE unconditionally.
REQ-022 mem_rdata SHALL be registered on entry to RESPOND.
- Source: buffered line on a hit; pmem_rdata on a fill.
- Value held until the next RESPOND.
REQ-023 Extraction at offset o:
- mask 11: {byte[o+1], byte[o]}; at o=15 the upper byte is 8'h00.
- mask 01: {8'h00, byte[o]}.
- mask 10: {byte[o], 8'h00}.
- mask 00: 16'h0000.
REQ-024 inval with valid=1 and tag match SHALL clear valid at the next edge, in any state.
REQ-025 inval matching the in-flight fetch tag in the same cycle as pmem_resp (or during FETCH):
- Data SHALL still be returned.
- valid SHALL end at 0.
REQ-026 inval SHALL take priority over a same-cycle IDLE hit; that request is treated as a miss.
REQ-027 pmem_resp outside FETCH SHALL be ignored.

Reset
REQ-028 On rst the block SHALL set:
- state = IDLE;
- valid = 0;
- mem_resp = 0, pmem_read = 0;
- mem_rdata = 0, pmem_address = 0;
- tag = 0, line = 0.
REQ-029 rst during FETCH SHALL drop pmem_read in the next cycle, and a late pmem_resp SHALL be ignored.
REQ-030 rst SHALL override every other input in the same cycle.

Structure
REQ-031 lc3b_types SHALL provide lc3b_word, lc3b_mem_wmask, lc3b_c_line (128), lc3b_c_tag (12) and lc3b_c_offset (4).
REQ-032 The state enum SHALL be local to the module.
REQ-033 Byte selection SHALL be one combinational sub-module, data_extract (line, offset, mask -> word).
- Instantiated once.
- Fed by a mux of buffered line vs pmem_rdata.

Verification
All scenarios use a line whose byte i = 8'h10+i.
REQ-034 Miss fill: after reset, read 0x1234 mask 11.
- pmem_read asserts next cycle with pmem_address 0x1230.
- After pmem_resp: mem_resp = 1 and mem_rdata = 0x1514 one cycle later.
REQ-035 Hit: after REQ-034, read 0x123F mask 11.
- mem_resp next cycle with mem_rdata = 0x001F.
- pmem_read stays 0.
REQ-036 Byte lanes on the buffered line:
- 0x1236 mask 10 -> 0x1600.
- 0x1237 mask 01 -> 0x0017.
- mask 00 -> 0x0000.
REQ-037 Inval priority: inval_address 0x123A in the same cycle as a read of 0x1230 -> FETCH entered, pmem_read = 1.
REQ-038 Inval at fill: inval 0x1230 coincident with pmem_resp.
- That read returns correct data.
- The next read of 0x1230 misses.
REQ-039 Reset mid-fetch: rst while in FETCH.
- pmem_read = 0 next cycle.
- pmem_resp two cycles later produces no mem_resp.
- A subsequent read of 0x1230 misses.

Source files
------------

// File: rtl/lc3b_types.sv
// Shared LC-3b memory-path types: CPU words, byte masks, cache-line pieces.
package lc3b_types;

  localparam int unsigned WORD_W   = 16;
  localparam int unsigned WMASK_W  = 2;
  localparam int unsigned LINE_W   = 128;
  localparam int unsigned TAG_W    = 12;
  localparam int unsigned OFFSET_W = 4;

  typedef logic [WORD_W-1:0]   lc3b_word;
  typedef logic [WMASK_W-1:0]  lc3b_mem_wmask;
  typedef logic [LINE_W-1:0]   lc3b_c_line;
  typedef logic [TAG_W-1:0]    lc3b_c_tag;
  typedef logic [OFFSET_W-1:0] lc3b_c_offset;

endpackage

// File: rtl/data_extract.sv
// Combinational byte-lane selection of one CPU word out of a 16-byte line.
module data_extract
  import lc3b_types::*;
(
  input  lc3b_c_line    i_line,
  input  lc3b_c_offset  i_offset,
  input  lc3b_mem_wmask i_mask,
  output lc3b_word      o_word_c
);

  lc3b_c_offset w_hi_offset;
  logic [7:0]   w_lo_byte;
  logic [7:0]   w_hi_byte;

  assign w_hi_offset = 4'(i_offset + 4'd1);
  assign w_lo_byte   = i_line[{i_offset, 3'b000} +: 8];
  // Upper byte would run past the end of the line at offset 15.
  assign w_hi_byte   = (i_offset == 4'hF) ? 8'h00 : i_line[{w_hi_offset, 3'b000} +: 8];

  always_comb begin
    o_word_c = 16'h0000;
    case (i_mask)
      2'b11:   o_word_c = {w_hi_byte, w_lo_byte};
      2'b01:   o_word_c = {8'h00, w_lo_byte};
      2'b10:   o_word_c = {w_lo_byte, 8'h00};
      default: o_word_c = 16'h0000;
    endcase
  end

endmodule

// File: rtl/line_read_buffer.sv
// Single-line read buffer in front of physical memory, with invalidation
// snooping from the write path.
module line_read_buffer
  import lc3b_types::*;
(
  input  logic          clk,
  input  logic          rst,
  input  lc3b_word      mem_address,
  input  logic          mem_read,
  input  lc3b_mem_wmask mem_byte_enable,
  output lc3b_word      mem_rdata,
  output logic          mem_resp,
  output lc3b_word      pmem_address,
  output logic          pmem_read,
  input  lc3b_c_line    pmem_rdata,
  input  logic          pmem_resp,
  input  logic          inval,
  input  lc3b_word      inval_address
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_FETCH   = 2'd1;
  localparam logic [1:0] S_RESPOND = 2'd2;

  logic [1:0] r_state;
  logic       r_valid;
  lc3b_c_tag  r_tag;
  lc3b_c_line r_line;
  logic       r_kill;
  lc3b_word   r_mem_rdata;
  logic       r_mem_resp;
  logic       r_pmem_read;
  lc3b_word   r_pmem_address;

  logic [1:0] w_state_nxt;
  logic       w_valid_nxt;
  lc3b_c_tag  w_tag_nxt;
  lc3b_c_line w_line_nxt;
  logic       w_kill_nxt;
  lc3b_word   w_mem_rdata_nxt;
  logic       w_mem_resp_nxt;
  logic       w_pmem_read_nxt;
  lc3b_word   w_pmem_address_nxt;

  logic       w_inval_buf;
  logic       w_inval_fetch;
  logic       w_hit;
  lc3b_c_line w_src_line;
  lc3b_word   w_word;

  assign w_inval_buf   = inval && r_valid && (inval_address[15:4] == r_tag);
  assign w_inval_fetch = inval && (inval_address[15:4] == r_pmem_address[15:4]);
  // A same-cycle invalidate of the buffered line demotes a hit to a miss.
  assign w_hit         = r_valid && (mem_address[15:4] == r_tag) && !w_inval_buf;
  assign w_src_line    = (r_state == S_FETCH) ? pmem_rdata : r_line;

  data_extract u_extract (
    .i_line   (w_src_line),
    .i_offset (mem_address[3:0]),
    .i_mask   (mem_byte_enable),
    .o_word_c (w_word)
  );

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt        = r_state;
    w_valid_nxt        = r_valid;
    w_tag_nxt          = r_tag;
    w_line_nxt         = r_line;
    w_kill_nxt         = r_kill;
    w_mem_rdata_nxt    = r_mem_rdata;
    w_mem_resp_nxt     = 1'b0;
    w_pmem_read_nxt    = r_pmem_read;
    w_pmem_address_nxt = r_pmem_address;

    if (w_inval_buf) w_valid_nxt = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (mem_read) begin
          if (w_hit) begin
            w_state_nxt     = S_RESPOND;
            w_mem_resp_nxt  = 1'b1;
            w_mem_rdata_nxt = w_word;
          end else begin
            w_state_nxt        = S_FETCH;
            w_pmem_read_nxt    = 1'b1;
            w_pmem_address_nxt = {mem_address[15:4], 4'h0};
            w_kill_nxt         = 1'b0;
          end
        end
      end
      S_FETCH: begin
        if (w_inval_fetch) w_kill_nxt = 1'b1;
        if (pmem_resp) begin
          // Data is still returned, but an invalidate seen during the fetch
          // leaves the freshly loaded line marked invalid.
          w_state_nxt     = S_RESPOND;
          w_mem_resp_nxt  = 1'b1;
          w_pmem_read_nxt = 1'b0;
          w_line_nxt      = pmem_rdata;
          w_tag_nxt       = r_pmem_address[15:4];
          w_valid_nxt     = !(r_kill || w_inval_fetch);
          w_mem_rdata_nxt = w_word;
          w_kill_nxt      = 1'b0;
        end
      end
      S_RESPOND: w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_valid        <= 1'b0;
      r_tag          <= '0;
      r_line         <= '0;
      r_kill         <= 1'b0;
      r_mem_rdata    <= '0;
      r_mem_resp     <= 1'b0;
      r_pmem_read    <= 1'b0;
      r_pmem_address <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_valid        <= w_valid_nxt;
      r_tag          <= w_tag_nxt;
      r_line         <= w_line_nxt;
      r_kill         <= w_kill_nxt;
      r_mem_rdata    <= w_mem_rdata_nxt;
      r_mem_resp     <= w_mem_resp_nxt;
      r_pmem_read    <= w_pmem_read_nxt;
      r_pmem_address <= w_pmem_address_nxt;
    end
  end

  assign mem_rdata    = r_mem_rdata;
  assign mem_resp     = r_mem_resp;
  assign pmem_address = r_pmem_address;
  assign pmem_read    = r_pmem_read;

endmodule
